mips_mc_control: RTL and testbench
==================================

// Module: mips_mc_control
// PURPOSE
//  Multicycle main control FSM for the MIPS datapath; the driving end of the ALU interface.
//  Decodes opcode and sequences fetch/decode/execute/memory/writeback over several cycles.
//  Drives ALUOp/ALUSrc into ALUControl/alu and consumes the ALU's Zero/overflow.
//  Handshakes with a variable-latency unified memory via mem_ready.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready in any memory state before bus error
//  OVF_TRAP     1   1: suppress RegWrite and pulse ovf_exc on ADD/SUB/ADDI overflow; 0: ignore overflow
// PORTS
//  clk        in   1  rising-edge clock
//  reset      in   1  asynchronous, active-high reset
//  opcode     in   6  instr[31:26] from the instruction register
//  funct      in   6  instr[5:0], used only for overflow qualification
//  Zero       in   1  ALU zero flag
//  overflow   in   1  ALU signed overflow flag
//  mem_ready  in   1  memory has completed the current read or write
//  MemRead    out  1  memory read request
//  MemWrite   out  1  memory write request
//  IorD       out  1  memory address: 0 = PC, 1 = ALUOut
//  IRWrite    out  1  load the instruction register
//  PCWrite    out  1  load PC from the PCSrc mux
//  PCSrc      out  2  00 PC+4, 01 branch target, 10 jump target
//  RegDst     out  1  register write address: 0 = rt, 1 = rd
//  MemtoReg   out  1  write-back data: 0 = ALUOut, 1 = MDR
//  RegWrite   out  1  register file write enable
//  ALUSrc     out  1  ALU operand B: 0 = RD2, 1 = SignImm
//  ALUOp      out  2  00 R-type, 01 LW/SW/ADDI, 10 BEQ, 11 BNE
//  ovf_exc    out  1  one-cycle pulse: overflowing write-back suppressed
//  bus_err    out  1  sticky: memory timeout
//  illegal_op out  1  sticky: undefined opcode
// BEHAVIOUR
//  Moore outputs decoded from the state register; every output not listed for a state is 0.
//  While reset is high: state = FETCH, all outputs 0, wait counter 0, ovf_q 0, sticky flags 0.
//  Opcodes: R 000000, LW 100011, SW 101011, ADDI 001000, BEQ 000100, BNE 000101, J 000010.
//  FETCH    : MemRead=1, IorD=0.
//             On mem_ready: IRWrite=1, PCWrite=1, PCSrc=00, go to DECODE; otherwise stay.
//  DECODE   : no strobes. R -> EXEC; LW/SW -> MEMADDR; ADDI -> ADDIEX; BEQ/BNE -> BRANCH;
//             J -> JUMP; any other opcode -> TRAP with illegal_op set.
//  MEMADDR  : ALUSrc=1, ALUOp=01, overflow ignored. LW -> MEMRD; SW -> MEMWR.
//  MEMRD    : MemRead=1, IorD=1. On mem_ready go to MEMWB.
//  MEMWB    : RegWrite=1, MemtoReg=1, RegDst=0, then FETCH.
//  MEMWR    : MemWrite=1, IorD=1. On mem_ready go to FETCH.
//  EXEC     : ALUSrc=0, ALUOp=00.
//             ovf_q <= overflow & (funct==100000 | funct==100010). Go to ALUWB.
//  ALUWB    : RegDst=1, RegWrite = ~(OVF_TRAP & ovf_q), ovf_exc = OVF_TRAP & ovf_q, then FETCH.
//  ADDIEX   : ALUSrc=1, ALUOp=01, ovf_q <= overflow. Go to ADDIWB.
//  ADDIWB   : RegDst=0, RegWrite/ovf_exc rule as in ALUWB, then FETCH.
//  BRANCH   : ALUSrc=0, ALUOp = 10 (BEQ) / 11 (BNE), PCSrc=01.
//             PCWrite = BEQ ? Zero : ~Zero. Then FETCH.
//  JUMP     : PCWrite=1, PCSrc=10, then FETCH.
//  TRAP     : all strobes 0; held until reset.
//  Latency: R/ADDI 4 cycles, LW 5, SW 4, BEQ/BNE/J 3, plus (memory wait cycles).
//  Wait counter: cleared on entering FETCH/MEMRD/MEMWR; increments each cycle mem_ready=0.
//    Reaching MEM_TIMEOUT-1 with mem_ready=0 -> TRAP, bus_err=1; strobes drop on the next cycle.
//    mem_ready on the same cycle as the timeout compare wins (normal completion).
//  mem_ready outside memory states is ignored.
//  Reset mid-instruction aborts it; no write strobe is issued after reset asserts.
// TESTING
//  ADD with mem_ready tied 1: 4 cycles FETCH,DECODE,EXEC,ALUWB; RegWrite=1, RegDst=1 only in cycle 4.
//  LW with mem_ready delayed 3 cycles in FETCH and in MEMRD:
//    total 11 cycles; MemtoReg=1 and RegWrite=1 in the last cycle.
//  BEQ Zero=1 -> PCWrite=1, PCSrc=01, ALUOp=10.
//    BNE Zero=1 -> PCWrite=0, ALUOp=11; both return to FETCH.
//  ADD 0x7FFFFFFF+1 (overflow=1, OVF_TRAP=1): RegWrite=0 and ovf_exc=1 in ALUWB.
//    ADDU funct=100001 with overflow=1: RegWrite=1.
//  Opcode 111111 -> illegal_op=1, stays in TRAP.
//    mem_ready held 0 for MEM_TIMEOUT cycles -> bus_err=1; reset clears both flags.
//  Assert reset during MEMWR: MemWrite=0 immediately; after release, FETCH with MemRead=1.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with a variable-latency memory and raises sticky bus/illegal-opcode flags.
module mips_mc_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit OVF_TRAP    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic       ovf_exc,
    output logic       bus_err,
    output logic       illegal_op,
    output logic [3:0] dbg_state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] wait_cnt, wait_cnt_n;
    logic          ovf_q, ovf_n;
    logic          bus_set, ill_set;
    logic          mem_state;

    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            ovf_q      <= 1'b0;
            bus_err    <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            ovf_q    <= ovf_n;
            if (bus_set) bus_err <= 1'b1;
            if (ill_set) illegal_op <= 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        ovf_n      = ovf_q;
        bus_set    = 1'b0;
        ill_set    = 1'b0;
        wait_cnt_n = wait_cnt;
        case (state)
            S_FETCH:   if (mem_ready) state_n = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:           state_n = S_EXEC;
                    OP_LW, OP_SW:   state_n = S_MEMADDR;
                    OP_ADDI:        state_n = S_ADDIEX;
                    OP_BEQ, OP_BNE: state_n = S_BRANCH;
                    OP_J:           state_n = S_JUMP;
                    default: begin
                        state_n = S_TRAP;
                        ill_set = 1'b1;
                    end
                endcase
            end
            S_MEMADDR: state_n = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_n = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_n = S_FETCH;
            S_EXEC: begin
                // Only signed ADD/SUB can trap; ADDU/SUBU wrap silently.
                ovf_n   = overflow & ((funct == FN_ADD) | (funct == FN_SUB));
                state_n = S_ALUWB;
            end
            S_ADDIEX: begin
                ovf_n   = overflow;
                state_n = S_ADDIWB;
            end
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_n = S_FETCH;
            S_TRAP:    state_n = S_TRAP;
            default:   state_n = S_FETCH;
        endcase
        // A completing mem_ready on the last allowed cycle takes priority over the timeout.
        if (mem_state && !mem_ready && (wait_cnt == CNT_LAST)) begin
            state_n = S_TRAP;
            bus_set = 1'b1;
        end
        if (state_n != state) wait_cnt_n = '0;
        else if (mem_state && !mem_ready) wait_cnt_n = wait_cnt + 1'b1;
    end

    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 2'b00;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 2'b00;
        ovf_exc  = 1'b0;
        // Gating with reset keeps every strobe low from the moment reset rises.
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_MEMADDR, S_ADDIEX: begin
                    ALUSrc = 1'b1;
                    ALUOp  = 2'b01;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_ALUWB, S_ADDIWB: begin
                    RegDst   = (state == S_ALUWB);
                    RegWrite = ~(OVF_TRAP & ovf_q);
                    ovf_exc  = OVF_TRAP & ovf_q;
                end
                S_BRANCH: begin
                    ALUOp   = (opcode == OP_BNE) ? 2'b11 : 2'b10;
                    PCSrc   = 2'b01;
                    PCWrite = (opcode == OP_BNE) ? ~Zero : Zero;
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: instruction-level reference model pushes per-cycle expected
// output words into a queue; a negedge monitor pops and compares them.
module tb_mips_mc_control;

    localparam int W           = 16;
    localparam int MEM_TIMEOUT = 16;
    localparam bit OVF_TRAP    = 1'b1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    // Expected-word bit masks: {MemRead,MemWrite,IorD,IRWrite,PCWrite,PCSrc,RegDst,
    // MemtoReg,RegWrite,ALUSrc,ALUOp,ovf_exc,bus_err,illegal_op}
    localparam logic [W-1:0] MR      = 16'h8000;
    localparam logic [W-1:0] MW      = 16'h4000;
    localparam logic [W-1:0] IOD     = 16'h2000;
    localparam logic [W-1:0] IRW     = 16'h1000;
    localparam logic [W-1:0] PCW     = 16'h0800;
    localparam logic [W-1:0] PCS_J   = 16'h0400;
    localparam logic [W-1:0] PCS_BR  = 16'h0200;
    localparam logic [W-1:0] RDST    = 16'h0100;
    localparam logic [W-1:0] M2R     = 16'h0080;
    localparam logic [W-1:0] RW      = 16'h0040;
    localparam logic [W-1:0] ASRC    = 16'h0020;
    localparam logic [W-1:0] AOP_BEQ = 16'h0010;
    localparam logic [W-1:0] AOP_MEM = 16'h0008;
    localparam logic [W-1:0] AOP_BNE = 16'h0018;
    localparam logic [W-1:0] OVE     = 16'h0004;
    localparam logic [W-1:0] BUS     = 16'h0002;
    localparam logic [W-1:0] ILL     = 16'h0001;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       Zero, overflow, mem_ready;
    logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, RegDst, MemtoReg, RegWrite, ALUSrc;
    logic [1:0] PCSrc, ALUOp;
    logic       ovf_exc, bus_err, illegal_op;
    logic [3:0] dbg_state;
    logic [W-1:0] act;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           total  = 0;
    int           passes = 0;
    logic         exp_bus = 1'b0;
    logic         exp_ill = 1'b0;
    logic [5:0]   cur_op = 6'd0;
    logic [5:0]   cur_fn = 6'd0;

    always #5 clk = ~clk;

    mips_mc_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .OVF_TRAP(OVF_TRAP)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
        .overflow(overflow), .mem_ready(mem_ready), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .ovf_exc(ovf_exc), .bus_err(bus_err), .illegal_op(illegal_op), .dbg_state(dbg_state)
    );

    assign act = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, RegDst, MemtoReg,
                  RegWrite, ALUSrc, ALUOp, ovf_exc, bus_err, illegal_op};

    // Monitor
    initial begin
        logic [W-1:0] e;
        string        n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                total++;
                if (act === e) passes++;
                else $display("FAIL %s: got %b expected %b (t=%0t)", n, act, e, $time);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [W-1:0] flags();
        return (exp_bus ? BUS : 16'h0) | (exp_ill ? ILL : 16'h0);
    endfunction

    task automatic cyc(input logic rdy, input logic z, input logic ov, input logic [W-1:0] e,
                       input string n);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        opcode    = cur_op;
        funct     = cur_fn;
        mem_ready = rdy;
        Zero      = z;
        overflow  = ov;
        exp_q.push_back(e | flags());
        name_q.push_back(n);
    endtask

    task automatic rst_cyc();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_ready = rb();
        Zero      = rb();
        overflow  = rb();
        exp_bus   = 1'b0;
        exp_ill   = 1'b0;
        exp_q.push_back(16'h0);
        name_q.push_back("reset");
    endtask

    // Memory access of n_wait stall cycles; at MEM_TIMEOUT stalls it ends in a bus error.
    task automatic mem_phase(input logic [W-1:0] bits, input logic [W-1:0] done_bits,
                             input int n_wait, input string n, output logic to);
        to = 1'b0;
        for (int i = 0; i < n_wait && i < MEM_TIMEOUT; i++) cyc(1'b0, rb(), rb(), bits, n);
        if (n_wait >= MEM_TIMEOUT) begin
            to      = 1'b1;
            exp_bus = 1'b1;
            for (int i = 0; i < 3; i++) cyc(rb(), rb(), rb(), 16'h0, "bus_trap");
            rst_cyc();
            rst_cyc();
        end else begin
            cyc(1'b1, rb(), rb(), bits | done_bits, n);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input logic z, input logic ov);
        logic to;
        logic hit;
        cur_op = op;
        cur_fn = fn;
        mem_phase(MR, IRW | PCW, fw, "fetch", to);
        if (!to) begin
            cyc(rb(), rb(), rb(), 16'h0, "decode");
            case (op)
                OP_R: begin
                    hit = ov && (fn == 6'b100000 || fn == 6'b100010) && OVF_TRAP;
                    cyc(rb(), rb(), ov, 16'h0, "exec");
                    cyc(rb(), rb(), rb(), RDST | (hit ? OVE : RW), "aluwb");
                end
                OP_ADDI: begin
                    hit = ov && OVF_TRAP;
                    cyc(rb(), rb(), ov, ASRC | AOP_MEM, "addiex");
                    cyc(rb(), rb(), rb(), hit ? OVE : RW, "addiwb");
                end
                OP_LW: begin
                    cyc(rb(), rb(), rb(), ASRC | AOP_MEM, "memaddr");
                    mem_phase(MR | IOD, 16'h0, mw, "memrd", to);
                    if (!to) cyc(rb(), rb(), rb(), RW | M2R, "memwb");
                end
                OP_SW: begin
                    cyc(rb(), rb(), rb(), ASRC | AOP_MEM, "memaddr");
                    mem_phase(MW | IOD, 16'h0, mw, "memwr", to);
                end
                OP_BEQ: cyc(rb(), z, rb(), AOP_BEQ | PCS_BR | (z ? PCW : 16'h0), "beq");
                OP_BNE: cyc(rb(), z, rb(), AOP_BNE | PCS_BR | (z ? 16'h0 : PCW), "bne");
                OP_J:   cyc(rb(), rb(), rb(), PCW | PCS_J, "jump");
                default: begin
                    exp_ill = 1'b1;
                    for (int i = 0; i < 3; i++) cyc(rb(), rb(), rb(), 16'h0, "illegal_trap");
                    rst_cyc();
                    rst_cyc();
                end
            endcase
        end
    endtask

    function automatic int rand_wait();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(15, 16));
        return int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic       to;
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] bad_ops[4];
        logic [5:0] fns[4];
        bad_ops = '{6'b111111, 6'b000001, 6'b100000, 6'b001111};
        fns     = '{6'b100000, 6'b100010, 6'b100001, 6'b100100};
        reset = 1'b1;
        opcode = 6'd0;
        funct = 6'd0;
        Zero = 1'b0;
        overflow = 1'b0;
        mem_ready = 1'b0;
        rst_cyc();
        rst_cyc();

        run_instr(OP_R, 6'b100000, 0, 0, 1'b0, 1'b0);
        run_instr(OP_LW, 6'd0, 3, 3, 1'b0, 1'b0);
        run_instr(OP_BEQ, 6'd0, 0, 0, 1'b1, 1'b0);
        run_instr(OP_BNE, 6'd0, 0, 0, 1'b1, 1'b0);
        run_instr(OP_BEQ, 6'd0, 1, 0, 1'b0, 1'b0);
        run_instr(OP_BNE, 6'd0, 0, 0, 1'b0, 1'b0);
        run_instr(OP_R, 6'b100000, 0, 0, 1'b0, 1'b1);
        run_instr(OP_R, 6'b100001, 0, 0, 1'b0, 1'b1);
        run_instr(OP_R, 6'b100010, 0, 0, 1'b0, 1'b1);
        run_instr(OP_ADDI, 6'd0, 0, 0, 1'b0, 1'b1);
        run_instr(OP_ADDI, 6'd0, 2, 0, 1'b0, 1'b0);
        run_instr(OP_J, 6'd0, 0, 0, 1'b0, 1'b0);
        run_instr(OP_SW, 6'd0, 0, 2, 1'b0, 1'b0);
        run_instr(OP_LW, 6'd0, 15, 15, 1'b0, 1'b0);
        run_instr(OP_SW, 6'd0, 0, 15, 1'b0, 1'b0);
        run_instr(6'b111111, 6'd0, 0, 0, 1'b0, 1'b0);
        run_instr(OP_R, 6'b100000, 16, 0, 1'b0, 1'b0);
        run_instr(OP_LW, 6'd0, 0, 16, 1'b0, 1'b0);
        run_instr(OP_SW, 6'd0, 0, 16, 1'b0, 1'b0);

        // Reset arriving while a store is waiting on memory.
        cur_op = OP_SW;
        cur_fn = 6'd0;
        mem_phase(MR, IRW | PCW, 0, "fetch", to);
        cyc(rb(), rb(), rb(), 16'h0, "decode");
        cyc(rb(), rb(), rb(), ASRC | AOP_MEM, "memaddr");
        cyc(1'b0, rb(), rb(), MW | IOD, "memwr_wait");
        rst_cyc();
        rst_cyc();
        run_instr(OP_R, 6'b100000, 1, 0, 1'b0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            fn  = fns[$urandom_range(0, 3)];
            if (sel <= 2 || sel >= 17) op = OP_R;
            else if (sel <= 5)  op = OP_LW;
            else if (sel <= 8)  op = OP_SW;
            else if (sel <= 10) op = OP_ADDI;
            else if (sel <= 12) op = OP_BEQ;
            else if (sel <= 14) op = OP_BNE;
            else if (sel == 15) op = OP_J;
            else op = bad_ops[$urandom_range(0, 3)];
            run_instr(op, fn, rand_wait(), rand_wait(), rb(), rb());
        end

        @(posedge clk);
        @(posedge clk);
        total++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
